hazard_scoreboard: RTL and testbench

//  D-stage hazard unit for the 5-stage MIPS pipeline; successor to the stage-compare stall logic.
//  Per-register countdown table of pending Tnew (E-stage frame) replaces the E/M address compares.

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: per-register pending-Tnew countdown table plus MDU busy sequencer.
// Optional HAZ_STAT_EN adds free-running stall statistics counters.
module hazard_scoreboard #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned TNEW_W   = 2,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [$clog2(NREG)-1:0]  id_rs,
  input  logic [$clog2(NREG)-1:0]  id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [TNEW_W-1:0]        id_tuse_rs,
  input  logic [TNEW_W-1:0]        id_tuse_rt,
  input  logic                     id_wr_en,
  input  logic [$clog2(NREG)-1:0]  id_wr_addr,
  input  logic [TNEW_W-1:0]        id_tnew,
  input  logic                     id_is_md,
  input  logic                     flush_e,
  input  logic                     md_start,
  input  logic                     md_is_div,
`ifdef HAZ_STAT_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              md_stall_cnt,
`endif
  output logic                     stall,
  output logic                     md_busy
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned MDC_W   = $clog2(MAX_LAT + 1);

  logic [TNEW_W-1:0] pend     [NREG];
  logic [TNEW_W-1:0] pend_nxt [NREG];
  logic [MDC_W-1:0]  mdc;
  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              issue;

  // Outputs are forced low while reset is held so stale state never leaks out.
  always_comb begin
    md_busy  = reset & (mdc != '0);
    stall_rs = reset & id_valid & id_use_rs & (id_rs != '0) & (pend[id_rs] > id_tuse_rs);
    stall_rt = reset & id_valid & id_use_rt & (id_rt != '0) & (pend[id_rt] > id_tuse_rt);
    stall_md = reset & id_valid & id_is_md & ((mdc != '0) | md_start);
    stall    = stall_rs | stall_rt | stall_md;
    issue    = id_valid & ~stall & ~flush_e;
  end

  // Decrement everything, then let the newly issued writer override its own entry.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      pend_nxt[r] = (pend[r] != '0) ? pend[r] - TNEW_W'(1) : '0;
    end
    if (issue && id_wr_en && (id_wr_addr != '0)) begin
      pend_nxt[id_wr_addr] = id_tnew;
    end
    pend_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        pend[r] <= pend_nxt[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdc <= '0;
    end else if (md_start && (mdc == '0)) begin
      mdc <= md_is_div ? MDC_W'(DIV_LAT) : MDC_W'(MULT_LAT);
    end else if (mdc != '0) begin
      mdc <= mdc - MDC_W'(1);
    end
  end

`ifdef HAZ_STAT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (stall_md) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard, with hand-written MDU sequences.
// Statistic counter checks are compiled in when HAZ_STAT_EN is defined.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [1:0] id_tuse_rs;
  logic [1:0] id_tuse_rt;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic [1:0] id_tnew;
  logic       id_is_md;
  logic       flush_e;
  logic       md_start;
  logic       md_is_div;
  logic       stall;
  logic       md_busy;
`ifdef HAZ_STAT_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;
`endif

  hazard_scoreboard #(
    .NREG     (32),
    .TNEW_W   (2),
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_tnew    (id_tnew),
    .id_is_md   (id_is_md),
    .flush_e    (flush_e),
    .md_start   (md_start),
    .md_is_div  (md_is_div),
`ifdef HAZ_STAT_EN
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt),
`endif
    .stall      (stall),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs;
    logic       ur;
    logic [1:0] tr;
    logic [4:0] rt;
    logic       ut;
    logic [1:0] tt;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       md;
    logic       fl;
    logic       ms;
    logic       dv;
    logic       es;
    logic       eb;
  } vec_t;

  int unsigned n_vec;
  int unsigned n_err;
  vec_t        tbl[$];

  function automatic vec_t mk(int rst, int v, int rs, int ur, int tr, int rt, int ut, int tt,
                              int we, int wa, int tn, int md, int fl, int ms, int dv,
                              int es, int eb);
    vec_t m;
    m.rst = 1'(rst); m.v  = 1'(v);  m.rs = 5'(rs); m.ur = 1'(ur); m.tr = 2'(tr);
    m.rt  = 5'(rt);  m.ut = 1'(ut); m.tt = 2'(tt); m.we = 1'(we); m.wa = 5'(wa);
    m.tn  = 2'(tn);  m.md = 1'(md); m.fl = 1'(fl); m.ms = 1'(ms); m.dv = 1'(dv);
    m.es  = 1'(es);  m.eb = 1'(eb);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t m, input string name);
    reset = m.rst; id_valid = m.v; id_rs = m.rs; id_use_rs = m.ur; id_tuse_rs = m.tr;
    id_rt = m.rt; id_use_rt = m.ut; id_tuse_rt = m.tt; id_wr_en = m.we; id_wr_addr = m.wa;
    id_tnew = m.tn; id_is_md = m.md; flush_e = m.fl; md_start = m.ms; md_is_div = m.dv;
    #4;
    chk({name, "_stall"}, {31'd0, stall}, {31'd0, m.es});
    chk({name, "_busy"}, {31'd0, md_busy}, {31'd0, m.eb});
    @(posedge clk);
    #1;
  endtask

  // mflo sits in D while a mult/div starts; a second md_start at cycle 'poke' must be ignored.
  task automatic md_seq(input int is_div, input int lat, input int poke, input string name);
    step(mk(1,1, 0,0,0, 0,0,0, 1,10,1, 1,0,1,is_div, 1,0), {name, "_start"});
    for (int k = 1; k <= lat; k++) begin
      step(mk(1,1, 0,0,0, 0,0,0, 1,10,1, 1,0,(k == poke) ? 1 : 0,1, 1,1),
           $sformatf("%s_busy%0d", name, k));
    end
    step(mk(1,1, 0,0,0, 0,0,0, 1,10,1, 1,0,0,0, 0,0), {name, "_done"});
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0), {name, "_idle"});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //          rst v  rs ur tr rt ut tt we wa tn md fl ms dv es eb
    tbl.push_back(mk(0,1, 0,0,0, 0,0,0, 0,0,0, 1,0,1,1, 0,0)); // reset with MDU request present
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,1,2, 0,0,0,0, 0,0)); // lw $1
    tbl.push_back(mk(1,1, 1,1,1, 0,0,0, 1,2,1, 0,0,0,0, 1,0)); // addu $2,$1 stalls once
    tbl.push_back(mk(1,1, 1,1,1, 0,0,0, 1,2,1, 0,0,0,0, 0,0)); // pend == tuse: issue
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,1,2, 0,0,0,0, 0,0)); // lw $1
    tbl.push_back(mk(1,1, 1,1,0, 4,1,0, 0,0,0, 0,0,0,0, 1,0)); // beq $1,$4
    tbl.push_back(mk(1,1, 1,1,0, 4,1,0, 0,0,0, 0,0,0,0, 1,0));
    tbl.push_back(mk(1,1, 1,1,0, 4,1,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,1,1, 0,0,0,0, 0,0)); // addu $1 tnew=1
    tbl.push_back(mk(1,1, 4,1,0, 1,1,0, 0,0,0, 0,0,0,0, 1,0)); // beq $4,$1 (rt path)
    tbl.push_back(mk(1,1, 4,1,0, 1,1,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,0,2, 0,0,0,0, 0,0)); // write $0
    tbl.push_back(mk(1,1, 0,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,1,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,6,2, 0,0,0,0, 0,0)); // lw $6
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,6,0, 0,0,0,0, 0,0)); // newer writer $6 tnew=0
    tbl.push_back(mk(1,1, 6,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,0, 7,1,0, 0,0,0, 1,7,3, 0,0,0,0, 0,0)); // invalid D: no update
    tbl.push_back(mk(1,1, 7,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,8,2, 0,0,0,0, 0,0)); // lw $8
    tbl.push_back(mk(1,1, 8,1,0, 0,0,0, 1,9,3, 0,0,0,0, 1,0)); // stalled writer of $9
    tbl.push_back(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 9,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,3,2, 0,1,0,0, 0,0)); // lw $3 flushed
    tbl.push_back(mk(1,1, 3,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 0,0,0, 0,0,0, 1,5,2, 0,0,0,0, 0,0)); // lw $5
    tbl.push_back(mk(0,1, 5,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0)); // reset while pend[5]=2
    tbl.push_back(mk(1,1, 5,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));

    foreach (tbl[i]) begin
      step(tbl[i], $sformatf("v%0d", i));
    end

    md_seq(1, 10, 4, "div");
`ifdef HAZ_STAT_EN
    chk("div_stall_cnt", stall_cnt, 32'd11);
    chk("div_md_stall_cnt", md_stall_cnt, 32'd11);
`endif
    md_seq(0, 5, 2, "mult");
`ifdef HAZ_STAT_EN
    chk("mult_stall_cnt", stall_cnt, 32'd17);
    chk("mult_md_stall_cnt", md_stall_cnt, 32'd17);
`endif

    // MDU busy with no MDU instruction in D: busy runs, no stall.
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,1,0, 0,0), "bg_start");
    step(mk(1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,1), "bg_inv_md");
    for (int k = 2; k <= 5; k++) begin
      step(mk(1,1, 0,0,0, 0,0,0, 1,11,1, 0,0,0,0, 0,1), $sformatf("bg_alu%0d", k));
    end
    step(mk(1,1, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0), "bg_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
